// File: rtl/de2_115_qsys_key_pio.sv
// Avalon-MM input PIO for the DE2-115 keys.
// Sync, debounce, falling-edge capture (W1C) and masked level irq.
module de2_115_qsys_key_pio #(
  parameter int              WIDTH           = 4,
  parameter int              DEBOUNCE_CYCLES = 1000,
  parameter logic [WIDTH-1:0] IDLE_LEVEL     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_nxt;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] cap_nxt;
  logic [WIDTH-1:0] clr;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic             wr;
  logic             unused_wd;

  assign wr        = chipselect && !write_n;
  assign unused_wd = ^(writedata >> WIDTH);

  // A counter only runs while the synced level disagrees with deb.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      deb_nxt[i] = deb[i];
      cnt_nxt[i] = '0;
      if (sync2[i] != deb[i]) begin
        if (cnt[i] == LAST) begin
          deb_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  // A press landing on a clearing write wins.
  always_comb begin
    clr = '0;
    if (wr && address == 2'd3) begin
      clr = writedata[WIDTH-1:0];
    end
    cap_nxt = (cap & ~clr) | (deb & ~deb_nxt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
      deb   <= IDLE_LEVEL;
      mask  <= '0;
      cap   <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      deb   <= deb_nxt;
      cap   <= cap_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      if (wr && address == 2'd2) begin
        mask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0:    readdata = 32'(deb);
      2'd2:    readdata = 32'(mask);
      2'd3:    readdata = 32'(cap);
      default: readdata = '0;
    endcase
  end

  assign irq = |(cap & mask);

endmodule

// File: tb/tb_de2_115_qsys_key_pio.sv
// Bench for de2_115_qsys_key_pio: directed steps plus random traffic
// against a window-based reference model of the key path.
module tb_de2_115_qsys_key_pio;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  in_port;

  int checks = 0;
  int errors = 0;

  de2_115_qsys_key_pio #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq),
    .in_port(in_port)
  );

  always #5 clk = ~clk;

  // Reference: raw samples pass through two stages, then a key level
  // is accepted once the last D synced samples all oppose it.
  logic [3:0] pipe [$];
  logic [3:0] win  [$];
  logic [3:0] deb_m;
  logic [3:0] mask_m;
  logic [3:0] cap_m;

  task automatic model_reset();
    pipe   = {4'hF, 4'hF};
    win    = {};
    deb_m  = 4'hF;
    mask_m = 4'h0;
    cap_m  = 4'h0;
  endtask

  task automatic model_edge();
    logic [3:0] s2;
    logic [3:0] nd;
    logic [3:0] clr;
    bit         all;
    s2 = pipe[0];
    pipe.delete(0);
    pipe.push_back(in_port);
    win.push_back(s2);
    if (win.size() > D) win.delete(0);
    nd = deb_m;
    for (int i = 0; i < 4; i++) begin
      all = (win.size() == D);
      foreach (win[j]) if (win[j][i] == deb_m[i]) all = 0;
      if (all) nd[i] = ~deb_m[i];
    end
    clr = 4'h0;
    if (chipselect && !write_n) begin
      if (address == 2'd3) clr = writedata[3:0];
      if (address == 2'd2) mask_m = writedata[3:0];
    end
    cap_m = (cap_m & ~clr) | (deb_m & ~nd);
    deb_m = nd;
  endtask

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {28'h0, deb_m};
      2'd2:    return {28'h0, mask_m};
      2'd3:    return {28'h0, cap_m};
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: model follows the edge, outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    chk("rd_model", readdata, exp_rd(address));
    chk("irq_model", {31'h0, irq}, {31'h0, |(cap_m & mask_m)});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic peek(input logic [1:0] a, input logic [31:0] exp,
                      input string tag);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  task automatic check_reset_vals(input string tag);
    peek(2'd0, 32'hF, {tag, "_data"});
    peek(2'd2, 32'h0, {tag, "_mask"});
    peek(2'd3, 32'h0, {tag, "_cap"});
    chk({tag, "_irq"}, {31'h0, irq}, 32'h0);
  endtask

  initial begin
    reset      = 1'b1;
    in_port    = 4'hF;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("reset");
    reset = 1'b0;
    peek(2'd1, 32'h0, "reserved");

    // Press key 0 with mask 1.
    bus_wr(2'd2, 32'h1);
    bus_wr(2'd1, 32'hFFFF_FFFF);
    peek(2'd2, 32'h1, "mask_rd");
    address = 2'd0;
    in_port = 4'hE;
    tick();
    ticks(7);
    tick();
    peek(2'd0, 32'hF, "press_early");
    tick();
    peek(2'd0, 32'hE, "press_data");
    peek(2'd3, 32'h1, "press_cap");
    chk("press_irq", {31'h0, irq}, 32'h1);

    // Release does not capture; then clear.
    in_port = 4'hF;
    ticks(12);
    peek(2'd3, 32'h1, "release_cap");
    bus_wr(2'd3, 32'h1);
    peek(2'd3, 32'h0, "clr_cap");
    chk("clr_irq", {31'h0, irq}, 32'h0);

    // Seven-cycle glitch on key 1.
    in_port = 4'hD;
    ticks(7);
    in_port = 4'hF;
    ticks(12);
    peek(2'd0, 32'hF, "glitch_data");
    peek(2'd3, 32'h0, "glitch_cap");
    chk("glitch_irq", {31'h0, irq}, 32'h0);

    // W1C on a two-bit capture.
    in_port = 4'hC;
    ticks(12);
    in_port = 4'hF;
    ticks(12);
    peek(2'd3, 32'h3, "w1c_pre");
    bus_wr(2'd3, 32'h1);
    peek(2'd3, 32'h2, "w1c_one");
    bus_wr(2'd3, 32'h0);
    peek(2'd3, 32'h2, "w1c_zero");
    chk("w1c_irq", {31'h0, irq}, 32'h0);

    // Clearing key 2 on the very edge it is captured.
    in_port = 4'hB;
    tick();
    ticks(8);
    bus_wr(2'd3, 32'h4);
    peek(2'd3, 32'h6, "collide_cap");
    in_port = 4'hF;
    ticks(12);

    // Mask toggling over a pending capture.
    bus_wr(2'd2, 32'h2);
    chk("mask_on_irq", {31'h0, irq}, 32'h1);
    bus_wr(2'd2, 32'h0);
    chk("mask_off_irq", {31'h0, irq}, 32'h0);

    // Reset while key 0 counter holds 5.
    in_port = 4'hE;
    tick();
    ticks(6);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_vals("midrst");
    @(posedge clk);
    #2;
    check_reset_vals("midrst_hold");
    reset = 1'b0;
    address = 2'd3;
    ticks(D + 1);
    peek(2'd3, 32'h0, "rearm_early");
    tick();
    peek(2'd3, 32'h1, "rearm_cap");
    in_port = 4'hF;
    ticks(12);

    // Random traffic: slow-changing keys and random bus accesses.
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) in_port[b] = ~in_port[b];
      end
      address = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        chipselect = 1'($urandom_range(0, 1));
        write_n    = 1'($urandom_range(0, 1));
        writedata  = $urandom;
      end else begin
        chipselect = 1'b0;
        write_n    = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/de2_115_qsys_key_pio.md
# de2_115_qsys_key_pio

Avalon-MM slave input PIO for the DE2-115 push-buttons. It is the read-side companion of the LED output PIO on the same Qsys bus. It synchronises and debounces the `WIDTH` active-low key inputs and latches falling edges in a write-1-to-clear capture register. It raises a level interrupt to the Nios II when any captured edge is unmasked.

## Interface
- `WIDTH`, 4, number of key inputs (1..32)
- `DEBOUNCE_CYCLES`, 1000, consecutive stable clk cycles required before a level change is accepted (minimum 1)
- `IDLE_LEVEL`, {WIDTH{1'b1}}, reset value of the synchroniser and debounced registers (keys released = high)

- `clk`  in  1  system clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `address`  in  2  register select
- `chipselect`  in  1  slave select
- `write_n`  in  1  active-low write strobe
- `writedata`  in  32  write data
- `readdata`  out  32  read data; combinational, zero wait states
- `irq`  out  1  level interrupt, active high
- `in_port`  in  WIDTH  raw asynchronous key inputs

## Operation
- Register map. Unused bits read 0.
  - addr 0 DATA: RO, debounced key levels in [WIDTH-1:0].
  - addr 1: reserved, reads 0, writes ignored.
  - addr 2 IRQ_MASK: RW, bits [WIDTH-1:0].
  - addr 3 EDGE_CAPTURE: RO, write-1-to-clear per bit.
- A write occurs when `chipselect && !write_n`. Writes to addr 0 and addr 1 have no effect.
- Synchroniser: two flops per bit (`sync1`, `sync2`), both reset to IDLE_LEVEL.
- Debounce, per bit, using an independent counter of width clog2(DEBOUNCE_CYCLES+1):
  - If `sync2 == deb`, the counter is cleared to 0.
  - Otherwise the counter increments. When the counter equals DEBOUNCE_CYCLES-1 on a clock edge, `deb` takes `sync2` on that edge and the counter is cleared.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches `deb`.
- Edge capture: bit i is set on the edge where `deb[i]` transitions 1->0 (key press). A release (0->1) does not set it.
- Clear: a write to addr 3 with `writedata[i]=1` clears bit i.
- Simultaneous set and clear of the same bit in the same cycle: set wins, and the bit remains 1.
- `irq = |(EDGE_CAPTURE & IRQ_MASK)`. This is combinational from registers, so there is no glitch from `in_port`.
- Reset values:
  - `sync1`, `sync2` and `deb` = IDLE_LEVEL.
  - Counters = 0.
  - IRQ_MASK = 0 and EDGE_CAPTURE = 0.
  - `irq` = 0.
  - `readdata` = 0 unless address 0 is selected, in which case it shows IDLE_LEVEL.
- `readdata` ignores `chipselect`; it is a pure address mux of the current register values.

## Timing
- An `in_port` change stable before rising edge E0 appears in `sync2` after edge E0+1.
- `deb` changes at edge E0+1+DEBOUNCE_CYCLES, assuming the input stays stable.
- The EDGE_CAPTURE bit sets on that same edge. `irq`, if unmasked, is high immediately after that edge.
- Register writes take effect on the clock edge of the write cycle and are visible on `readdata` in the next cycle.
- Writing IRQ_MASK with a captured bit already pending asserts `irq` the cycle after the write. Clearing the mask deasserts it the cycle after.
- Asserting `reset` mid-count immediately zeroes all counters and returns all registers to reset values. After release, an `in_port` held low is treated as a new press and is captured after the full debounce delay.
- Counters saturate only through the clear-on-accept rule and never wrap.

## Test plan
- Reset check: apply reset with `in_port`=4'hF. Required: addr0 reads 0xF, addr2 reads 0, addr3 reads 0, `irq`=0.
- Press with DEBOUNCE_CYCLES=8 and IRQ_MASK=4'h1: drive `in_port`=4'hE and hold.
  - addr0 reads 0xE exactly 9 cycles after the first sampling edge.
  - addr3 reads 0x1 and `irq`=1 on that same edge.
- Glitch rejection: pulse `in_port[1]` low for 7 cycles with DEBOUNCE_CYCLES=8. Required: addr0 and addr3 are unchanged and `irq` stays 0.
- Write-1-to-clear:
  - With addr3=0x3, write 0x1 to addr3. Required: addr3=0x2.
  - Then write 0x0 to addr3. Required: addr3 is still 0x2.
  - With IRQ_MASK=0x1, `irq`=0.
- Set-clear collision: write 0x4 to addr3 on the exact edge where `deb[2]` falls. Required: addr3[2]=1 afterwards.
- Reset mid-count:
  - Assert reset while the key 0 counter holds 5, with the key still low. Required: all registers return to reset values.
  - After release, bit 0 is captured 2+DEBOUNCE_CYCLES cycles later.
